// File: rtl/input_conditioner.sv
// rtl/input_conditioner.sv - synchronizer, debouncer and edge/long-press detector for button inputs
//
// Purpose: conditions WIDTH asynchronous button/switch inputs into clean levels
//          plus one-cycle rise/fall pulses for downstream control FSMs.
//          Each channel passes through a SYNC_STAGES flop chain.
//          A per-channel counter then accepts a new value only after it has
//          persisted for DEBOUNCE_CYCLES consecutive cycles.
// Optional feature: define INPUT_COND_HOLD_EN to build a per-channel
//          long-press detector. Without it, `held` is tied to 0.
// Ports:
//   clock   in   1      system clock
//   reset   in   1      synchronous, active-high reset
//   din     in   WIDTH  raw asynchronous inputs
//   level   out  WIDTH  synchronized, debounced level (registered)
//   rise    out  WIDTH  one-cycle pulse when level goes 0->1
//   fall    out  WIDTH  one-cycle pulse when level goes 1->0
//   changed out  1      OR of rise|fall, coincident with them
//   held    out  WIDTH  one-cycle long-press pulse (0 unless INPUT_COND_HOLD_EN)

module input_conditioner #(
    parameter int               WIDTH           = 5,
    parameter int               SYNC_STAGES     = 2,
    parameter int               DEBOUNCE_CYCLES = 16,
    parameter logic [WIDTH-1:0] RESET_VALUE     = 5'b10000,
    parameter int               HOLD_CYCLES     = 1024
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] level,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             changed,
    output logic [WIDTH-1:0] held
);

    localparam int             CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    if (SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 1 || HOLD_CYCLES < 1) begin : g_param_check
        $error("input_conditioner: illegal parameter value");
    end

    logic [WIDTH-1:0] r_sync [SYNC_STAGES];
    logic [CW-1:0]    r_cnt  [WIDTH];

    logic [WIDTH-1:0] w_s;
    logic [WIDTH-1:0] w_diff;
    logic [WIDTH-1:0] w_accept;

    // A channel's new value is accepted on the edge where it has already
    // differed from level for DEBOUNCE_CYCLES-1 counted edges.
    always_comb begin
        w_s    = r_sync[SYNC_STAGES-1];
        w_diff = w_s ^ level;
        for (int i = 0; i < WIDTH; i++) begin
            w_accept[i] = w_diff[i] && (r_cnt[i] == CNT_LAST);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                r_sync[k] <= RESET_VALUE;
            end
            for (int i = 0; i < WIDTH; i++) begin
                r_cnt[i] <= '0;
            end
            level   <= RESET_VALUE;
            rise    <= '0;
            fall    <= '0;
            changed <= 1'b0;
        end else begin
            r_sync[0] <= din;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                r_sync[k] <= r_sync[k-1];
            end
            // Any return to level (a glitch) restarts the window from zero.
            for (int i = 0; i < WIDTH; i++) begin
                if (!w_diff[i] || w_accept[i]) begin
                    r_cnt[i] <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                end
            end
            level   <= (level & ~w_accept) | (w_s & w_accept);
            rise    <= w_accept & w_s;
            fall    <= w_accept & ~w_s;
            changed <= |w_accept;
        end
    end

`ifdef INPUT_COND_HOLD_EN
    localparam int            HW        = $clog2(HOLD_CYCLES + 1);
    localparam logic [HW-1:0] HOLD_MAX  = HW'(HOLD_CYCLES);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

    logic [HW-1:0] r_hcnt [WIDTH];

    // The counter is zero on the edge that raises level, so held fires
    // exactly HOLD_CYCLES edges after the rise pulse. Saturation at
    // HOLD_MAX keeps it from firing again until a release re-arms it.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < WIDTH; i++) begin
                r_hcnt[i] <= '0;
            end
            held <= '0;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (!level[i] || (w_accept[i] && w_s[i])) begin
                    r_hcnt[i] <= '0;
                end else if (r_hcnt[i] != HOLD_MAX) begin
                    r_hcnt[i] <= r_hcnt[i] + 1'b1;
                end
                held[i] <= level[i] && (r_hcnt[i] == HOLD_LAST);
            end
        end
    end
`else
    assign held = '0;
`endif

endmodule

// File: tb/tb_input_conditioner.sv
// tb/tb_input_conditioner.sv - directed-vector bench for input_conditioner

module tb_input_conditioner;

    logic       clock = 1'b0;
    logic       reset;
    logic [4:0] din;
    logic [4:0] level, rise, fall, held;
    logic       changed;

    int n_vec = 0;
    int n_err = 0;

    logic [4:0] rq[$], fq[$], hq[$];
    logic       cq[$];
    logic [4:0] held_any = '0;

    input_conditioner #(.HOLD_CYCLES(8)) dut (
        .clock  (clock),
        .reset  (reset),
        .din    (din),
        .level  (level),
        .rise   (rise),
        .fall   (fall),
        .changed(changed),
        .held   (held)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        rq.delete(); fq.delete(); hq.delete(); cq.delete();
    endtask

    // Index 0 of the log is the first edge after the call (edge E0).
    task automatic run(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
            rq.push_back(rise);
            fq.push_back(fall);
            hq.push_back(held);
            cq.push_back(changed);
            held_any = held_any | held;
        end
    endtask

    function automatic logic [4:0] get(input int kind, input int idx);
        if (idx < 0 || idx >= rq.size()) return 5'bx;
        case (kind)
            0:       return rq[idx];
            1:       return fq[idx];
            2:       return hq[idx];
            default: return {4'b0, cq[idx]};
        endcase
    endfunction

    function automatic int count(input int kind, input logic [4:0] mask);
        int c = 0;
        for (int i = 0; i < rq.size(); i++) if ((get(kind, i) & mask) != 0) c++;
        return c;
    endfunction

    function automatic int first(input int kind, input logic [4:0] mask);
        for (int i = 0; i < rq.size(); i++) if ((get(kind, i) & mask) != 0) return i;
        return -1;
    endfunction

    localparam int RISE = 0, FALL = 1, HELD = 2, CHG = 3;

    initial begin
        // reset state
        reset = 1'b1;
        din   = 5'b00000;
        repeat (3) @(posedge clock);
        #1;
        check("rst_level",   level,   5'b10000);
        check("rst_rise",    rise,    5'b00000);
        check("rst_fall",    fall,    5'b00000);
        check("rst_changed", changed, 1'b0);
        check("rst_held",    held,    5'b00000);

        // chain flushes RESET_VALUE, fall[4] after the debounce latency
        reset = 1'b0;
        clr();
        run(40);
        check("flush_fall4_idx", first(FALL, 5'b10000), 17);
        check("flush_fall4_cnt", count(FALL, 5'b10000), 1);
        check("flush_rise_cnt",  count(RISE, 5'b11111), 0);
        check("flush_level",     level, 5'b00000);

        // clean rising edge on channel 2
        din[2] = 1'b1;
        clr();
        run(40);
        check("r2_idx",       first(RISE, 5'b00100), 17);
        check("r2_cnt",       count(RISE, 5'b00100), 1);
        check("r2_chg_idx",   first(CHG, 5'b00001), 17);
        check("r2_chg_cnt",   count(CHG, 5'b00001), 1);
        check("r2_others",    count(RISE, 5'b11011) + count(FALL, 5'b11111), 0);
        check("r2_level",     level, 5'b00100);

        // bouncing channel 1: high 10, low 2, high; final rise edge is idx 12
        clr();
        din[1] = 1'b1; run(10);
        din[1] = 1'b0; run(2);
        din[1] = 1'b1; run(40);
        check("b1_rise_idx",  first(RISE, 5'b00010), 29);
        check("b1_rise_cnt",  count(RISE, 5'b00010), 1);
        check("b1_fall_cnt",  count(FALL, 5'b00010), 0);

        // opposite transitions on channels 0 and 3 in the same cycle
        din[3] = 1'b1;
        run(20);
        din[0] = 1'b1;
        din[3] = 1'b0;
        clr();
        run(40);
        check("x_rise0_idx", first(RISE, 5'b00001), 17);
        check("x_fall3_idx", first(FALL, 5'b01000), 17);
        check("x_rise_at17", get(RISE, 17), 5'b00001);
        check("x_fall_at17", get(FALL, 17), 5'b01000);
        check("x_chg_cnt",   count(CHG, 5'b00001), 1);

        // reset while channel 3 is mid-count (cnt reaches 12 at idx 13)
        din[3] = 1'b1;
        clr();
        run(14);
        reset = 1'b1;
        run(2);
        check("mr_no_pulse", count(RISE, 5'b11111) + count(FALL, 5'b11111) + count(CHG, 5'b00001), 0);
        check("mr_level",    level, 5'b10000);
        reset = 1'b0;
        clr();
        run(40);
        check("mr_rise_idx",  first(RISE, 5'b01111), 17);
        check("mr_rise_at17", get(RISE, 17), 5'b01111);
        check("mr_fall_at17", get(FALL, 17), 5'b10000);
        check("mr_chg_cnt",   count(CHG, 5'b00001), 1);
        check("mr_level_end", level, 5'b01111);
`ifdef INPUT_COND_HOLD_EN
        check("h_at25",     get(HELD, 25), 5'b01111);
        check("h3_cnt",     count(HELD, 5'b01000), 1);
`endif

        // release and press channel 3 again
        din[3] = 1'b0;
        run(30);
        din[3] = 1'b1;
        clr();
        run(40);
        check("p2_rise_idx", first(RISE, 5'b01000), 17);
`ifdef INPUT_COND_HOLD_EN
        check("h3b_idx",    first(HELD, 5'b01000), 25);
        check("h3b_cnt",    count(HELD, 5'b01000), 1);
`else
        check("held_never", held_any, 5'b00000);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
